// File: rtl/spi_read_sequencer.sv
// Read-transaction controller in front of spi_master: sends a command byte, then N dummy
// bytes, and packs the returned bytes into one response word. Option: SPI_SEQ_CHIP_RDY_EN.
module spi_read_sequencer #(
   parameter int unsigned MAX_BYTES      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [7:0]             req_cmd,
   input  logic [2:0]             req_len,
   output logic                   spi_start,
   output logic [7:0]             spi_data_in,
   input  logic                   spi_busy,
   input  logic                   spi_new_data,
   input  logic [7:0]             spi_data_out,
   input  logic                   spi_chip_rdy,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [8*MAX_BYTES-1:0] rsp_data,
   output logic [2:0]             rsp_len,
   output logic                   rsp_err
);

   localparam int unsigned W   = 8 * MAX_BYTES;
   localparam int unsigned CW  = $clog2(MAX_BYTES + 2);
   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
`ifdef SPI_SEQ_CHIP_RDY_EN
      WAIT_RDY,
`endif
      SEND,
      WAIT_BYTE,
      DONE
   } state_t;

   state_t          state;
   logic [7:0]      cmd_q;
   logic [CW-1:0]   byte_cnt;
   logic [CW-1:0]   len_clamp;
   logic            first_byte;
   logic [WDW-1:0]  wdog;
   logic            wd_expired;

   assign req_ready  = (state == IDLE);
   assign wd_expired = (wdog == WDW'(TIMEOUT_CYCLES - 1));

`ifndef SPI_SEQ_CHIP_RDY_EN
   logic unused_chip_rdy;
   assign unused_chip_rdy = spi_chip_rdy;
`endif

   always_comb begin
      if (32'(req_len) > MAX_BYTES) len_clamp = CW'(MAX_BYTES);
      else                          len_clamp = CW'(req_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cmd_q       <= '0;
         byte_cnt    <= '0;
         first_byte  <= 1'b0;
         wdog        <= '0;
         spi_start   <= 1'b0;
         spi_data_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_len     <= '0;
         rsp_err     <= 1'b0;
      end else begin
         spi_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  cmd_q      <= req_cmd;
                  byte_cnt   <= len_clamp + CW'(1);
                  first_byte <= 1'b1;
                  wdog       <= '0;
                  rsp_data   <= '0;
                  rsp_len    <= '0;
                  rsp_err    <= 1'b0;
`ifdef SPI_SEQ_CHIP_RDY_EN
                  state <= WAIT_RDY;
`else
                  // Command start issued straight from IDLE so it appears the cycle after accept.
                  if (!spi_busy) begin
                     spi_start   <= 1'b1;
                     spi_data_in <= req_cmd;
                     state       <= WAIT_BYTE;
                  end else begin
                     state <= SEND;
                  end
`endif
               end
            end
`ifdef SPI_SEQ_CHIP_RDY_EN
            WAIT_RDY: begin
               if (spi_chip_rdy) begin
                  wdog  <= '0;
                  state <= SEND;
               end else if (wd_expired) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  wdog      <= '0;
                  state     <= DONE;
               end else begin
                  wdog <= wdog + WDW'(1);
               end
            end
`endif
            SEND: begin
               if (!spi_busy) begin
                  spi_start   <= 1'b1;
                  spi_data_in <= first_byte ? cmd_q : 8'h00;
                  wdog        <= '0;
                  state       <= WAIT_BYTE;
               end
            end
            WAIT_BYTE: begin
               // A byte arriving on the expiry cycle still counts.
               if (spi_new_data) begin
                  wdog       <= '0;
                  byte_cnt   <= byte_cnt - CW'(1);
                  first_byte <= 1'b0;
                  if (!first_byte) begin
                     rsp_data <= W'({rsp_data, spi_data_out});
                     rsp_len  <= rsp_len + 3'd1;
                  end
                  if (byte_cnt == CW'(1)) begin
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= SEND;
                  end
               end else if (wd_expired) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  wdog      <= '0;
                  state     <= DONE;
               end else begin
                  wdog <= wdog + WDW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Bench for spi_read_sequencer: behavioural spi_master stand-in plus per-transaction
// expectations derived from the request, the bytes returned and any stalled byte.
module tb_spi_read_sequencer;
   localparam int unsigned MAX_BYTES      = 4;
   localparam int unsigned TIMEOUT_CYCLES = 32;
   localparam int unsigned W              = 8 * MAX_BYTES;

   logic         clk          = 1'b0;
   logic         rst          = 1'b1;
   logic         req_valid    = 1'b0;
   logic         req_ready;
   logic [7:0]   req_cmd      = '0;
   logic [2:0]   req_len      = '0;
   logic         spi_start;
   logic [7:0]   spi_data_in;
   logic         spi_busy     = 1'b0;
   logic         spi_new_data = 1'b0;
   logic [7:0]   spi_data_out = '0;
   logic         spi_chip_rdy = 1'b1;
   logic         rsp_valid;
   logic         rsp_ready    = 1'b0;
   logic [W-1:0] rsp_data;
   logic [2:0]   rsp_len;
   logic         rsp_err;

   spi_read_sequencer #(.MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
      .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
      .spi_new_data(spi_new_data), .spi_data_out(spi_data_out), .spi_chip_rdy(spi_chip_rdy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_len(rsp_len), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   // Per-transaction spi_master behaviour, indexed by byte position (0 = command).
   logic [7:0]  tx_byte  [8];
   int unsigned tx_delay [8];
   int          tx_hang  = -1;
   int unsigned start_cyc[8];
   int unsigned nd_cyc   [8];
   logic [7:0]  starts_q [$];
   int unsigned rem = 0, tail = 0;
   int unsigned cur_k = 0;
   logic [7:0]  cur_byte = '0;
   bit          cur_hang = 1'b0;

   logic [W-1:0] obs_data;
   int unsigned  obs_len, obs_err, obs_nstarts;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one cycle, sample just after the edge, then update the spi_master stand-in.
   task automatic tick();
      int unsigned k;
      @(posedge clk);
      #1;
      cyc++;
      if (spi_start) chk("start_while_busy", 64'(spi_busy), 64'd0);
      spi_new_data = 1'b0;
      spi_data_out = 8'($urandom);
      if (tail > 0) begin
         tail--;
         if (tail == 0) spi_busy = 1'b0;
      end
      if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            if (!cur_hang) begin
               spi_new_data  = 1'b1;
               spi_data_out  = cur_byte;
               nd_cyc[cur_k] = cyc;
               tail = $urandom_range(2, 0);
               if (tail == 0) spi_busy = 1'b0;
            end else begin
               spi_busy = 1'b0;
            end
         end
      end
      if (spi_start) begin
         k = starts_q.size();
         starts_q.push_back(spi_data_in);
         if (k < 8) begin
            start_cyc[k] = cyc;
            rem      = tx_delay[k];
            cur_byte = tx_byte[k];
            cur_hang = (int'(k) == tx_hang);
            cur_k    = k;
         end else begin
            rem      = 1;
            cur_hang = 1'b0;
         end
         spi_busy = 1'b1;
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; rem = 0; tail = 0; spi_busy = 1'b0; spi_new_data = 1'b0;
      req_valid = 1'b0; rsp_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk({tag, "_req_ready"},   64'(req_ready),   64'd1);
      chk({tag, "_spi_start"},   64'(spi_start),   64'd0);
      chk({tag, "_spi_data_in"}, 64'(spi_data_in), 64'd0);
      chk({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
      chk({tag, "_rsp_data"},    64'(rsp_data),    64'd0);
      chk({tag, "_rsp_len"},     64'(rsp_len),     64'd0);
      chk({tag, "_rsp_err"},     64'(rsp_err),     64'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 8; i++) begin
         tx_byte[i]  = 8'($urandom);
         tx_delay[i] = ($urandom_range(9, 0) == 0) ? TIMEOUT_CYCLES - 1 : $urandom_range(8, 1);
      end
   endtask

   task automatic wait_master_idle();
      for (int i = 0; i < 10 && (spi_busy || rem != 0); i++) tick();
   endtask

   // hang_idx: that byte's transfer never reports new_data; late_idx: that byte
   // reports new_data exactly TIMEOUT_CYCLES after its start (one cycle too late).
   task automatic run_txn(input logic [7:0] cmd, input int unsigned len_raw,
                          input int hang_idx, input int late_idx, input int unsigned hold);
      int unsigned L, nstarts, nrecv, exp_cyc, budget;
      int stop;
      logic [W-1:0] exp_data;
      L = (len_raw > MAX_BYTES) ? MAX_BYTES : len_raw;
      stop = -1;
      if (hang_idx >= 0 && hang_idx <= int'(L)) stop = hang_idx;
      if (late_idx >= 0 && late_idx <= int'(L)) begin
         tx_delay[late_idx] = TIMEOUT_CYCLES;
         if (stop < 0 || late_idx < stop) stop = late_idx;
      end
      tx_hang = hang_idx;
      nstarts = (stop < 0) ? L + 1 : unsigned'(stop) + 1;
      nrecv   = (stop < 0) ? L : ((stop > 0) ? unsigned'(stop) - 1 : 0);
      exp_data = '0;
      for (int unsigned i = 1; i <= nrecv; i++)
         exp_data = exp_data | (W'(tx_byte[i]) << (8 * (nrecv - i)));
      starts_q.delete();
      for (int i = 0; i < 8; i++) begin start_cyc[i] = 0; nd_cyc[i] = 0; end

      repeat ($urandom_range(2, 0)) begin
         if (!spi_busy && rem == 0 && $urandom_range(1, 0) == 1) spi_new_data = 1'b1;
         tick();
      end
      wait_master_idle();
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

      req_valid = 1'b1; req_cmd = cmd; req_len = 3'(len_raw);
      tick();
      req_valid = 1'b0;
      chk("start_latency", 64'(spi_start), 64'd1);
      chk("first_data_in", 64'(spi_data_in), 64'(cmd));

      budget = 0;
      while (!rsp_valid && budget < 8 * TIMEOUT_CYCLES) begin
         chk("busy_req_ready", 64'(req_ready), 64'd0);
         req_valid = 1'($urandom); req_cmd = 8'($urandom); req_len = 3'($urandom);
         tick();
         budget++;
      end
      if (!rsp_valid) begin
         chk("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
         req_valid = 1'b0;
         return;
      end

      exp_cyc = (stop < 0) ? nd_cyc[L] + 1 : start_cyc[stop] + TIMEOUT_CYCLES;
      chk("rsp_cycle", 64'(cyc), 64'(exp_cyc));
      chk("n_starts", 64'(starts_q.size()), 64'(nstarts));
      foreach (starts_q[i]) chk("start_byte", 64'(starts_q[i]), (i == 0) ? 64'(cmd) : 64'd0);
      chk("rsp_data", 64'(rsp_data), 64'(exp_data));
      chk("rsp_len",  64'(rsp_len),  64'(nrecv));
      chk("rsp_err",  64'(rsp_err),  (stop >= 0) ? 64'd1 : 64'd0);
      obs_data = rsp_data; obs_len = 32'(rsp_len); obs_err = 32'(rsp_err);
      obs_nstarts = starts_q.size();

      for (int unsigned h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         req_valid = 1'($urandom); req_cmd = 8'($urandom); req_len = 3'($urandom);
         if (!spi_busy && rem == 0 && $urandom_range(2, 0) == 0) spi_new_data = 1'b1;
         tick();
         chk("hold_valid",     64'(rsp_valid), 64'd1);
         chk("hold_data",      64'(rsp_data),  64'(exp_data));
         chk("hold_len",       64'(rsp_len),   64'(nrecv));
         chk("hold_err",       64'(rsp_err),   (stop >= 0) ? 64'd1 : 64'd0);
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         chk("hold_start",     64'(spi_start), 64'd0);
      end
      rsp_ready = 1'b1; req_valid = 1'b0;
      tick();
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_req_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int unsigned budget;
      do_reset("reset");

      // Command only.
      fill_random();
      run_txn(8'hA5, 0, -1, -1, 1);
      chk("t1_len", 64'(obs_len), 64'd0);
      chk("t1_err", 64'(obs_err), 64'd0);
      chk("t1_starts", 64'(obs_nstarts), 64'd1);

      // Two data bytes after a discarded command response.
      fill_random();
      tx_byte[0] = 8'hFF; tx_byte[1] = 8'h12; tx_byte[2] = 8'h34;
      run_txn(8'h48, 2, -1, -1, 2);
      chk("t2_data", 64'(obs_data), 64'h1234);
      chk("t2_len", 64'(obs_len), 64'd2);

      // Oversized length clamps to MAX_BYTES.
      fill_random();
      tx_byte[0] = 8'hEE; tx_byte[1] = 8'h11; tx_byte[2] = 8'h22;
      tx_byte[3] = 8'h33; tx_byte[4] = 8'h44;
      run_txn(8'h3C, 7, -1, -1, 0);
      chk("t3_starts", 64'(obs_nstarts), 64'd5);
      chk("t3_data", 64'(obs_data), 64'h11223344);
      chk("t3_len", 64'(obs_len), 64'd4);

      // spi_master goes quiet after the first data byte.
      fill_random();
      tx_byte[1] = 8'h5A;
      run_txn(8'h90, 2, 2, -1, 1);
      chk("t4_err", 64'(obs_err), 64'd1);
      chk("t4_len", 64'(obs_len), 64'd1);
      chk("t4_data", 64'(obs_data), 64'h5A);

      // Consumer stalls for 20 cycles.
      fill_random();
      run_txn(8'h77, 3, -1, -1, 20);

      // Reset while the second byte is in flight, then a clean transaction.
      fill_random();
      for (int i = 1; i < 8; i++) tx_delay[i] = 6;
      tx_hang = -1;
      starts_q.delete();
      wait_master_idle();
      req_valid = 1'b1; req_cmd = 8'hC3; req_len = 3'd3;
      tick();
      req_valid = 1'b0;
      budget = 0;
      while (starts_q.size() < 2 && budget < 4 * TIMEOUT_CYCLES) begin
         tick();
         budget++;
      end
      chk("midrst_second_start", 64'(starts_q.size() >= 2), 64'd1);
      tick();
      do_reset("midrst");
      fill_random();
      run_txn(8'h21, 2, -1, -1, 1);

      // Every byte lands on the final permitted cycle.
      fill_random();
      for (int i = 0; i < 8; i++) tx_delay[i] = TIMEOUT_CYCLES - 1;
      run_txn(8'h0F, 2, -1, -1, 0);
      chk("edge_err", 64'(obs_err), 64'd0);

      // Byte arrives one cycle too late; command never answered.
      fill_random();
      run_txn(8'h66, 3, -1, 1, 1);
      chk("late_err", 64'(obs_err), 64'd1);
      chk("late_len", 64'(obs_len), 64'd0);
      fill_random();
      run_txn(8'h99, 2, 0, -1, 0);

      for (int t = 0; t < 40; t++) begin
         int unsigned len, lc;
         int hang, late;
         fill_random();
         len  = $urandom_range(7, 0);
         lc   = (len > MAX_BYTES) ? MAX_BYTES : len;
         hang = -1;
         late = -1;
         case ($urandom_range(9, 0))
            0, 1:    hang = int'($urandom_range(lc, 0));
            2:       late = int'($urandom_range(lc, 0));
            default: ;
         endcase
         run_txn(8'($urandom), len, hang, late, $urandom_range(4, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
